// File: rtl/tm1638_frame_ctrl.sv
// tm1638_frame_ctrl: TM1638 frame sequencer (refresh digits/LEDs, key scan when TM1638_KEY_SCAN_EN is defined)
module tm1638_frame_ctrl #(
  parameter int clk_mhz    = 50,
  parameter int refresh_hz = 100,
  parameter int gap_ns     = 1000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [63:0] digits,
  input  logic [7:0]  leds,
  input  logic [2:0]  brightness,
  input  logic        display_on,
  output logic [7:0]  keys,
  output logic        keys_valid,
  output logic        frame_busy,
  output logic        stb,
  output logic        dio_oe,
  output logic        sio_data_latch,
  output logic [7:0]  sio_data_in,
  output logic        sio_rw,
  input  logic        sio_busy,
  input  logic [7:0]  sio_data_out
);
  localparam int PERIOD  = clk_mhz * 1000000 / refresh_hz;
  localparam int GAP_RAW = (gap_ns * clk_mhz + 999) / 1000;
  localparam int GAP_CYC = GAP_RAW < 1 ? 1 : GAP_RAW;
  localparam int TW      = $clog2(PERIOD + 1);
  localparam int CW      = $clog2(GAP_CYC + 8);
`ifdef TM1638_KEY_SCAN_EN
  localparam logic [4:0] END_IDX = 5'd24;
`else
  localparam logic [4:0] END_IDX = 5'd19;
`endif
  typedef enum logic [2:0] {IDLE, START, SEND, WAIT_HI, WAIT_LO, GAP, DONE} state_t;
  state_t state, state_n;
  logic [TW-1:0] tmr;
  logic [CW-1:0] cnt;
  logic [4:0] idx;
  logic [63:0] dig_q;
  logic [7:0] led_q, cur_byte;
  logic [2:0] bri_q;
  logic [3:0] addr;
  logic on_q, tick, byte_done, rd_phase, unused_ok;
  assign tick = tmr == TW'(PERIOD - 1);
  assign byte_done = state == WAIT_LO && !sio_busy;
  assign unused_ok = ^sio_data_out;
`ifdef TM1638_KEY_SCAN_EN
  assign rd_phase = idx >= 5'd20 && idx <= 5'd23 && state != IDLE;
`else
  assign rd_phase = 1'b0;
`endif
  assign frame_busy = state != IDLE;
  assign stb = state == IDLE || state == DONE || (state == GAP && idx != 5'd20);
  assign dio_oe = !rd_phase;
  assign sio_rw = !rd_phase;
  assign sio_data_in = state == IDLE ? 8'h00 : cur_byte;
  assign sio_data_latch = state == SEND && !sio_busy;
  // Byte at the current frame position: commands, interleaved digit/LED data, dummy read byte
  always_comb begin
    addr = 4'(idx - 5'd2);
    cur_byte = idx == 5'd0  ? 8'h40 :
               idx == 5'd1  ? 8'hC0 :
               idx <  5'd18 ? (addr[0] ? {7'b0, led_q[addr[3:1]]} : dig_q[{addr[3:1], 3'b000} +: 8]) :
               idx == 5'd18 ? {4'b1000, on_q, bri_q} :
               idx == 5'd19 ? 8'h42 : 8'h00;
  end
  // Next state: frame start, byte handshake with busy-rise timeout, gaps and command boundaries
  always_comb begin
    state_n = state;
    case (state)
      IDLE:    state_n = tick ? START : IDLE;
      START:   state_n = SEND;
      SEND:    state_n = sio_busy ? SEND : WAIT_HI;
      WAIT_HI: state_n = sio_busy ? WAIT_LO : cnt == CW'(3) ? IDLE : WAIT_HI;
      WAIT_LO: state_n = sio_busy ? WAIT_LO : idx == 5'd23 ? DONE :
                         (idx == 5'd0 || idx == 5'd17 || idx == 5'd18 || idx == 5'd19) ? GAP : SEND;
      GAP:     state_n = cnt != CW'(GAP_CYC - 1) ? GAP : idx == 5'd20 ? SEND : idx == END_IDX ? DONE : START;
      DONE:    state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end
  // State register, refresh timer, per-state cycle counter, frame position and input snapshot
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      tmr <= '0;
      cnt <= '0;
      idx <= '0;
      dig_q <= '0;
      led_q <= '0;
      bri_q <= '0;
      on_q <= 1'b0;
    end else begin
      state <= state_n;
      tmr <= tick ? '0 : tmr + 1'b1;
      cnt <= state_n != state ? '0 : cnt + 1'b1;
      if (state == IDLE && tick) begin
        dig_q <= digits;
        led_q <= leds;
        bri_q <= brightness;
        on_q <= display_on;
        idx <= '0;
      end else if (byte_done) idx <= idx + 1'b1;
    end
  end
`ifdef TM1638_KEY_SCAN_EN
  logic [5:0] rd_q;
  // Gather bits 0 and 4 of each read byte; publish all 8 keys when the last read completes
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_q <= '0;
      keys <= '0;
      keys_valid <= 1'b0;
    end else begin
      keys_valid <= byte_done && idx == 5'd23;
      if (byte_done && rd_phase) rd_q <= {sio_data_out[4], sio_data_out[0], rd_q[5:2]};
      if (byte_done && idx == 5'd23) keys <= {sio_data_out[4], sio_data_out[0], rd_q};
    end
  end
`else
  assign keys = '0;
  assign keys_valid = 1'b0;
`endif
endmodule
